// File: rtl/sampling_vae_stream_pkg.sv
// ============================================================================
//  Module      : sampling_vae_stream_pkg
//  Description : Shared constants for the VAE reparameterisation sampler:
//                Q4.11 piecewise-sqrt table, LFSR polynomial, seed handling
//                and noise-mode encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sampling_vae_stream_pkg;

    // Fractional width the sqrt table below is expressed in.
    localparam int C_REF_FRAC = 11;
    localparam int C_NUM_SEG  = 9;

    // Segment breakpoints x1..x8 (Q4.11): 1/32, 1/16, 1/4, 1/2, 2, 4, 8, 12.
    localparam logic [15:0] C_SEG_X [0:7] = '{
        16'h0040, 16'h0080, 16'h0200, 16'h0400,
        16'h1000, 16'h2000, 16'h4000, 16'h6000
    };

    // Per-segment slope m and intercept c (Q4.11); sqrt(v) ~= m*v + c.
    localparam logic [15:0] C_SEG_M [0:8] = '{
        16'h2D41, 16'h12BF, 16'h0AAB, 16'h06A1, 16'h038D,
        16'h0258, 16'h01A8, 16'h0145, 16'h0112
    };
    localparam logic [15:0] C_SEG_C [0:8] = '{
        16'h0000, 16'h00D4, 16'h0155, 16'h0258, 16'h045D,
        16'h06A1, 16'h095F, 16'h0C75, 16'h0EDA
    };

    // Galois LFSR, x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] C_LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] C_SEED_DEF     = 16'hACE1;
    localparam logic [15:0] C_SEED_SPREAD  = 16'h1F35;
    localparam logic [15:0] C_SEED_NONZERO = 16'hACE1;

    typedef enum logic [1:0] {
        EPS_ZERO = 2'd0,
        EPS_LFSR = 2'd1,
        EPS_EXT  = 2'd2,
        EPS_RSVD = 2'd3
    } eps_mode_e;

    // Decorrelate channels by XOR-ing a per-channel offset into the seed;
    // an all-zero state would lock the LFSR, so it is substituted.
    function automatic logic [15:0] seed_spread(input logic [15:0] base, input int idx);
        logic [15:0] v;
        v = base ^ 16'(idx * int'(C_SEED_SPREAD));
        return (v == 16'h0000) ? C_SEED_NONZERO : v;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? C_LFSR_TAPS : 16'h0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sampling_lfsr.sv
// ============================================================================
//  Module      : sampling_lfsr
//  Description : One per-channel 16-bit Galois LFSR noise source with
//                synchronous load and accept-gated advance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sampling_lfsr
    import sampling_vae_stream_pkg::*;
#(
    parameter logic [15:0] RST_VAL = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] state
);

    // Load has priority over advance so a reseed is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_VAL;
        end else if (load) begin
            state <= load_val;
        end else if (adv) begin
            state <= lfsr_step(state);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sampling_vae_stream.sv
// ============================================================================
//  Module      : sampling_vae_stream
//  Description : Five-stage pipelined VAE sampler z = mu + sqrt(var) * eps
//                per channel, with valid/ready flow control, global stall,
//                and zero / LFSR / external noise selection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sampling_vae_stream
    import sampling_vae_stream_pkg::*;
#(
    parameter int          C        = 2,
    parameter int          WIDTH    = 16,
    parameter int          FRAC     = 11,
    parameter logic [15:0] SEED_DEF = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [C*WIDTH-1:0]   mu,
    input  logic [C*WIDTH-1:0]   var_in,
    input  logic [1:0]           eps_mode,
    input  logic [C*WIDTH-1:0]   eps_ext,
    input  logic                 seed_load,
    input  logic [15:0]          seed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [C*WIDTH-1:0]   z,
    output logic [C*WIDTH-1:0]   eps_out,
    output logic [C-1:0]         sat
);

    localparam int W   = WIDTH;
    localparam int W1  = WIDTH + 1;
    localparam int W2  = 2 * WIDTH;
    localparam int C_UP = (FRAC >= C_REF_FRAC) ? FRAC - C_REF_FRAC : 0;
    localparam int C_DN = (FRAC <  C_REF_FRAC) ? C_REF_FRAC - FRAC : 0;
    localparam int C_EPS_SH = 13 - FRAC;

    // Bring a Q4.11 table constant into the configured fixed-point format.
    function automatic logic signed [W-1:0] rescale(input logic [15:0] q);
        logic signed [31:0] v;
        v = 32'($signed(q));
        v = (v <<< C_UP) >>> C_DN;
        return W'(v);
    endfunction

    // Returns {m, c} of the sqrt segment covering a non-negative variance.
    function automatic logic [W2-1:0] seg_lookup(input logic signed [W-1:0] v);
        logic [3:0] k;
        k = 4'd0;
        for (int j = 0; j < C_NUM_SEG - 1; j++) begin
            if (v >= rescale(C_SEG_X[j])) k = 4'(j + 1);
        end
        return {rescale(C_SEG_M[k]), rescale(C_SEG_C[k])};
    endfunction

    // Fixed-point multiply, floor shift by FRAC, saturate; MSB = saturated.
    function automatic logic [W:0] mul_sat(input logic signed [W-1:0] a,
                                           input logic signed [W-1:0] b);
        logic signed [W2-1:0] prod;
        logic signed [W2-1:0] shf;
        prod = W2'(a) * W2'(b);
        shf  = prod >>> FRAC;
        if ((&shf[W2-1:W-1]) || !(|shf[W2-1:W-1]))
            return {1'b0, shf[W-1:0]};
        else if (shf[W2-1])
            return {1'b1, 1'b1, {(W-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(W-1){1'b1}}};
    endfunction

    // Saturating add on a WIDTH+1 sum; MSB = saturated.
    function automatic logic [W:0] add_sat(input logic signed [W-1:0] a,
                                           input logic signed [W-1:0] b);
        logic signed [W1-1:0] s;
        s = W1'(a) + W1'(b);
        if (s[W] == s[W-1])
            return {1'b0, s[W-1:0]};
        else if (s[W])
            return {1'b1, 1'b1, {(W-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(W-1){1'b1}}};
    endfunction

    logic w_en;
    logic w_accept;
    logic w_adv;
    logic r_v1, r_v2, r_v3, r_v4;

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;
    assign w_accept = in_valid && w_en;
    assign w_adv    = w_accept && (eps_mode == EPS_LFSR);

    // Valid bits travel with their data and freeze during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0; r_v4 <= 1'b0;
            out_valid <= 1'b0;
        end else if (w_en) begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            r_v4 <= r_v3;
            out_valid <= r_v4;
        end
    end

    for (genvar i = 0; i < C; i++) begin : g_ch
        logic signed [W-1:0] w_mu, w_var, w_var_cl, w_eps_ext, w_eps, w_m, w_c;
        logic signed [15:0]  w_lfsr_sx;
        logic [15:0]         w_lfsr, w_load_val;
        logic [W:0]          w_p, w_sig, w_q, w_zs;

        logic signed [W-1:0] r_s1_mu, r_s1_var, r_s1_eps, r_s1_m, r_s1_c;
        logic signed [W-1:0] r_s2_mu, r_s2_eps, r_s2_p, r_s2_c;
        logic signed [W-1:0] r_s3_mu, r_s3_eps, r_s3_sig;
        logic signed [W-1:0] r_s4_mu, r_s4_eps, r_s4_q;
        logic [W-1:0]        r_z, r_eps_o;
        logic                r_s2_sat, r_s3_sat, r_s4_sat, r_sat;

        assign w_mu       = mu[i*W +: W];
        assign w_var      = var_in[i*W +: W];
        assign w_eps_ext  = eps_ext[i*W +: W];
        assign w_var_cl   = w_var[W-1] ? '0 : w_var;
        assign {w_m, w_c} = seg_lookup(w_var_cl);
        assign w_load_val = seed_spread(seed, i);
        // Keep LFSR[FRAC+2:0] and sign-extend it: noise in [-4, 4).
        assign w_lfsr_sx  = $signed(w_lfsr << C_EPS_SH) >>> C_EPS_SH;

        sampling_lfsr #(
            .RST_VAL (seed_spread(SEED_DEF, i))
        ) u_lfsr (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv      (w_adv),
            .load     (seed_load),
            .load_val (w_load_val),
            .state    (w_lfsr)
        );

        // Noise source chosen per beat; the reserved mode behaves as zero.
        always_comb begin
            w_eps = '0;
            case (eps_mode)
                EPS_LFSR: w_eps = W'(w_lfsr_sx);
                EPS_EXT:  w_eps = w_eps_ext;
                default:  w_eps = '0;
            endcase
        end

        assign w_p   = mul_sat(r_s1_var, r_s1_m);
        assign w_sig = add_sat(r_s2_p, r_s2_c);
        assign w_q   = mul_sat(r_s3_sig, r_s3_eps);
        assign w_zs  = add_sat(r_s4_q, r_s4_mu);

        // Datapath S1..S5; saturation flags accumulate down the pipe.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1_mu <= '0; r_s1_var <= '0; r_s1_eps <= '0; r_s1_m <= '0; r_s1_c <= '0;
                r_s2_mu <= '0; r_s2_eps <= '0; r_s2_p <= '0; r_s2_c <= '0; r_s2_sat <= 1'b0;
                r_s3_mu <= '0; r_s3_eps <= '0; r_s3_sig <= '0; r_s3_sat <= 1'b0;
                r_s4_mu <= '0; r_s4_eps <= '0; r_s4_q <= '0; r_s4_sat <= 1'b0;
                r_z <= '0; r_eps_o <= '0; r_sat <= 1'b0;
            end else if (w_en) begin
                r_s1_mu  <= w_mu;
                r_s1_var <= w_var_cl;
                r_s1_eps <= w_eps;
                r_s1_m   <= w_m;
                r_s1_c   <= w_c;
                r_s2_mu  <= r_s1_mu;
                r_s2_eps <= r_s1_eps;
                r_s2_p   <= w_p[W-1:0];
                r_s2_c   <= r_s1_c;
                r_s2_sat <= w_p[W];
                r_s3_mu  <= r_s2_mu;
                r_s3_eps <= r_s2_eps;
                r_s3_sig <= w_sig[W-1:0];
                r_s3_sat <= r_s2_sat | w_sig[W];
                r_s4_mu  <= r_s3_mu;
                r_s4_eps <= r_s3_eps;
                r_s4_q   <= w_q[W-1:0];
                r_s4_sat <= r_s3_sat | w_q[W];
                r_z      <= w_zs[W-1:0];
                r_eps_o  <= r_s4_eps;
                r_sat    <= r_s4_sat | w_zs[W];
            end
        end

        assign z[i*W +: W]       = r_z;
        assign eps_out[i*W +: W] = r_eps_o;
        assign sat[i]            = r_sat;
    end

endmodule

`default_nettype wire

// File: tb/tb_sampling_vae_stream.sv
// ============================================================================
//  Module      : tb_sampling_vae_stream
//  Description : Directed self-checking bench for sampling_vae_stream
//                (C = 2, WIDTH = 16, FRAC = 11).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sampling_vae_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mu;
    logic [31:0] var_in;
    logic [1:0]  eps_mode;
    logic [31:0] eps_ext;
    logic        seed_load;
    logic [15:0] seed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic [31:0] eps_out;
    logic [1:0]  sat;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_lfsr [2];

    sampling_vae_stream #(
        .C(2), .WIDTH(16), .FRAC(11), .SEED_DEF(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mu(mu), .var_in(var_in), .eps_mode(eps_mode), .eps_ext(eps_ext),
        .seed_load(seed_load), .seed(seed), .out_valid(out_valid),
        .out_ready(out_ready), .z(z), .eps_out(eps_out), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference noise model
    function automatic logic [15:0] m_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction
    function automatic logic [15:0] m_eps(input logic [15:0] s);
        return {{2{s[13]}}, s[13:0]};
    endfunction
    function automatic logic [15:0] m_seed(input logic [15:0] b, input int ch);
        logic [15:0] v;
        v = (ch == 0) ? b : (b ^ 16'h1F35);
        return (v == 16'h0000) ? 16'hACE1 : v;
    endfunction
    function automatic logic [31:0] m_next_eps();
        logic [31:0] r;
        r = {m_eps(m_lfsr[1]), m_eps(m_lfsr[0])};
        m_lfsr[0] = m_step(m_lfsr[0]);
        m_lfsr[1] = m_step(m_lfsr[1]);
        return r;
    endfunction

    // One isolated beat; returns the output observed when it emerges.
    task automatic run_beat(input logic [1:0] md, input logic [31:0] mv, input logic [31:0] vv,
                            input logic [31:0] ev, input logic sl, input logic [15:0] sd,
                            output logic [31:0] zo, output logic [31:0] eo, output logic [1:0] so);
        bit got;
        @(negedge clk);
        eps_mode = md; mu = mv; var_in = vv; eps_ext = ev;
        seed_load = sl; seed = sd; out_ready = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; seed_load = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 12 && !got; t++) begin
            if (out_valid) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) chk("beat_timeout", 64'd0, 64'd1);
        zo = z; eo = eps_out; so = sat;
    endtask

    task automatic load_seed(input logic [15:0] sd);
        @(negedge clk);
        seed_load = 1'b1; seed = sd;
        @(negedge clk);
        seed_load = 1'b0;
        m_lfsr[0] = m_seed(sd, 0);
        m_lfsr[1] = m_seed(sd, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] zo, eo, held, e_exp;
        logic [1:0]  so;
        logic [31:0] exp_z [8];
        logic [31:0] exp_e [8];
        int snt, rcv, extra;
        bit acc;

        rst_n = 1'b0; in_valid = 1'b0; mu = '0; var_in = '0; eps_mode = 2'd0;
        eps_ext = '0; seed_load = 1'b0; seed = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_z", z, 32'h0);
        chk("rst_eps", eps_out, 32'h0);
        chk("rst_sat", sat, 2'b00);
        rst_n = 1'b1;

        // Latency: zero noise, one beat
        @(negedge clk);
        eps_mode = 2'd0; mu = {16'h0400, 16'h0400}; var_in = {16'h0800, 16'h0800};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("lat_valid_%0d", k), out_valid, (k == 5));
            if (k < 5) @(negedge clk);
        end
        chk("lat_z", z, {16'h0400, 16'h0400});
        chk("lat_eps", eps_out, 32'h0);
        chk("lat_sat", sat, 2'b00);
        @(negedge clk);
        chk("lat_single", out_valid, 1'b0);

        // External noise: var 1.0 -> sigma 0x07EA; negative var -> z = mu
        run_beat(2'd2, {16'h0123, 16'h0000}, {16'hF000, 16'h0800}, {16'h0800, 16'h0800},
                 1'b0, 16'h0, zo, eo, so);
        chk("ext_z", zo, {16'h0123, 16'h07EA});
        chk("ext_eps", eo, {16'h0800, 16'h0800});
        chk("ext_sat", so, 2'b00);

        // Breakpoint x4 = 0.5: 0x03FF in seg4, 0x0400 in seg5
        run_beat(2'd2, 32'h0, {16'h03FF, 16'h0400}, {16'h0800, 16'h0800},
                 1'b0, 16'h0, zo, eo, so);
        chk("brk_z", zo, {16'h05A7, 16'h0623});

        // Reserved mode acts as zero noise
        run_beat(2'd3, {16'h0222, 16'h0111}, {16'h0800, 16'h0800}, {16'h0800, 16'h0800},
                 1'b0, 16'h0, zo, eo, so);
        chk("rsvd_z", zo, {16'h0222, 16'h0111});
        chk("rsvd_eps", eo, 32'h0);

        // Saturation both directions
        run_beat(2'd2, {16'h8100, 16'h7F00}, {16'h3FFF, 16'h3FFF}, {16'h8000, 16'h7FFF},
                 1'b0, 16'h0, zo, eo, so);
        chk("sat_z", zo, {16'h8000, 16'h7FFF});
        chk("sat_flag", so, 2'b11);

        // LFSR determinism after seed 0x1234
        load_seed(16'h1234);
        for (int k = 0; k < 4; k++) begin
            e_exp = m_next_eps();
            run_beat(2'd1, 32'h0, 32'h0, 32'h0, 1'b0, 16'h0, zo, eo, so);
            chk($sformatf("lfsr_eps_%0d", k), eo, e_exp);
            chk($sformatf("lfsr_z_%0d", k), zo, 32'h0);
        end
        // Seed load coinciding with accept: beat uses pre-load state
        e_exp = m_next_eps();
        run_beat(2'd1, 32'h0, 32'h0, 32'h0, 1'b1, 16'h0000, zo, eo, so);
        chk("seed_coincide_eps", eo, e_exp);
        run_beat(2'd1, 32'h0, 32'h0, 32'h0, 1'b0, 16'h0, zo, eo, so);
        chk("seed_zero_eps", eo, {16'h1F35, 16'hECE1});

        // Backpressure: 8 back-to-back beats, 3-cycle output stall
        load_seed(16'h1234);
        for (int k = 0; k < 8; k++) begin
            exp_z[k] = {16'(16'h0200 + k), 16'(16'h0100 + k)};
            exp_e[k] = m_next_eps();
        end
        snt = 0; rcv = 0; held = '0;
        for (int t = 0; t < 80 && rcv < 8; t++) begin
            @(negedge clk);
            out_ready = !(t >= 6 && t <= 8);
            if (snt < 8) begin
                in_valid = 1'b1; eps_mode = 2'd1; var_in = 32'h0;
                mu = {16'(16'h0200 + snt), 16'(16'h0100 + snt)};
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                chk("bp_stall_ready", in_ready, 1'b0);
                if (t > 6) chk("bp_stall_hold", {out_valid, z}, {1'b1, held});
                held = z;
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp_z_%0d", rcv), z, exp_z[rcv]);
                chk($sformatf("bp_eps_%0d", rcv), eps_out, exp_e[rcv]);
                rcv++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) snt++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_count", rcv, 8);
        extra = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("bp_extra", extra, 0);
        e_exp = m_next_eps();
        run_beat(2'd1, 32'h0, 32'h0, 32'h0, 1'b0, 16'h0, zo, eo, so);
        chk("bp_adv_count", eo, e_exp);

        // Reset with beats in flight
        @(negedge clk);
        eps_mode = 2'd2; mu = {16'h0111, 16'h0111}; var_in = {16'h0800, 16'h0800};
        eps_ext = {16'h0800, 16'h0800}; in_valid = 1'b1; out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_valid_pre", out_valid, 1'b1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_z", z, 32'h0);
        chk("mid_rst_eps", eps_out, 32'h0);
        chk("mid_rst_sat", sat, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("mid_no_stale", extra, 0);
        run_beat(2'd1, 32'h0, 32'h0, 32'h0, 1'b0, 16'h0, zo, eo, so);
        chk("mid_seed_def_eps", eo, {16'hF3D4, 16'hECE1});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sampling_vae_stream.md
Name: sampling_vae_stream

Overview:
Next-generation VAE reparameterisation sampler: z = mu + sqrt(var) * eps, per channel, for C channels.
- Fully pipelined with valid/ready handshake and a global stall.
- Per-channel seedable LFSR noise, plus selectable noise modes (zero / LFSR / external) for deterministic inference and verification.
- Sits between the encoder's mean/variance dense layers and the decoder input.

Parameters:
- C, 2: channel count (1..16).
- WIDTH, 16: signed fixed-point word width.
- FRAC, 11: fractional bits; default format is Q4.11.
- SEED_DEF, 16'hACE1: reset seed for the LFSRs.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- mu  in  C*WIDTH  per-channel mean, signed; channel i at [(i+1)*WIDTH-1 : i*WIDTH].
- var_in  in  C*WIDTH  per-channel variance, signed.
- eps_mode  in  2  0 = zero noise, 1 = LFSR, 2 = external, 3 = reserved (treated as 0). Sampled on accept.
- eps_ext  in  C*WIDTH  external epsilon, used when eps_mode = 2.
- seed_load  in  1  reload all LFSRs from seed.
- seed  in  16  seed value.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- z  out  C*WIDTH  sampled output.
- eps_out  out  C*WIDTH  epsilon used for this beat, aligned with z.
- sat  out  C  per-channel saturation flag, aligned with z.

Behaviour:
- Reset: rst_n low asynchronously clears all stage valids, out_valid, z, eps_out and sat to 0. LFSR[i] returns to SEED_DEF ^ (i*16'h1F35); a zero result is replaced by 16'hACE1. Any in-flight data is discarded.
- Stall and handshake:
  - Global enable en = !out_valid || out_ready; in_ready = en.
  - Accept = in_valid && in_ready.
  - With en low, every stage register holds its value; valid bits travel with the data, and bubbles carry valid = 0.
- Pipeline: latency 5 cycles from accept to out_valid, throughput 1 beat/cycle.
  - S1: register mu, var and eps; select segment (m, c).
  - S2: p = var*m.
  - S3: sigma = p + c.
  - S4: q = sigma*eps.
  - S5: z = q + mu.
- Piecewise sqrt, 9 segments with breakpoints x1..x8:
  - v < x1 selects seg1.
  - x_k <= v < x_(k+1) selects seg k+1.
  - v >= x8 selects seg9.
  - Negative var clamps to 0, giving sigma = c1 = 0.
  - Constants are the team's standard Q4.11 sqrt table, e.g. m5 = 0x038D, c5 = 0x045D; for WIDTH/FRAC other than default the constants are rescaled at elaboration.
- Arithmetic:
  - Multiply: full 2*WIDTH product, arithmetic shift right by FRAC (truncation toward -inf), then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Add: WIDTH+1 sum, then saturate.
  - sat[i] = OR of all saturation events for channel i in S2..S5.
- Epsilon:
  - Per-channel 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - eps_lfsr = sign-extend of LFSR[FRAC+2:0] to WIDTH, giving range [-4, 4).
  - The LFSR advances only on accept with eps_mode = 1; it never advances while stalled.
- Seed load:
  - seed_load sets LFSR[i] <= seed ^ (i*16'h1F35), with a zero result replaced by 16'hACE1.
  - If seed_load coincides with an accept, the accepted beat uses the pre-load LFSR value and the load wins over the advance.
- Mode changes apply per beat; in-flight beats keep the mode they were accepted with.

Decomposition:
- Header sampling_defs.vh: segment m/c/x constants, NUM_SEG = 9, LFSR polynomial/taps, SEED_DEF, seed-spread constant 16'h1F35, eps_mode encodings.
- Sub-module sampling_lfsr: one per channel, with ports clk, rst_n, adv, load, load_val, state.
- The sqrt segment select is an inline function; the saturating mult/add are local functions.

Test Plan:
- eps_mode = 0, mu = 0x0400, var = 0x0800, in_valid for 1 cycle, out_ready = 1 -> out_valid exactly 5 cycles after accept, z = 0x0400, eps_out = 0, sat = 0.
- eps_mode = 2, mu = 0, var = 0x0800 (1.0), eps_ext = 0x0800 -> segment 5, sigma = 0x07EA, z = 0x07EA; with var = 0xF000 (negative) -> z = mu.
- Saturation: eps_mode = 2, mu = 0x7F00, var = 0x3FFF, eps_ext = 0x7FFF -> z = 0x7FFF, sat = 1; mirrored case with mu = 0x8100 and eps_ext = 0x8000 -> z = 0x8000, sat = 1.
- Backpressure: stream 8 beats back-to-back and hold out_ready = 0 for 3 cycles mid-stream -> in_ready = 0 during the stall, z/valid held stable, all 8 outputs in order with none duplicated or lost, and LFSR advance count = 8.
- LFSR determinism: seed_load with seed = 0x1234, then 4 beats in eps_mode = 1 -> eps_out matches the reference model sequence per channel; seed = 0x0000 on channel 0 -> state loads 0xACE1.
- Reset mid-stream: assert rst_n = 0 with 3 beats in flight -> out_valid drops immediately; after release, no stale beat is emitted and eps_out after one accept equals the SEED_DEF-derived first value.
